daq_frame_packer: RTL and testbench

//  Parametrised successor to the fixed 8x AD7606 packetizer. Drives CONVST, CS and RD for
//  NUM_ADC AD7606 devices sharing one data bus and one BUSY line. Packs each conversion into
//  a framed record (sync, sequence number, ADC mask, samples) and writes it into a

---
 rtl/daq_frame_packer.sv | 253 +++++++++++++++++++++++++
 tb/tb_daq_frame_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_packer.sv
// rtl/daq_frame_packer.sv - AD7606 multi-device conversion sequencer and FIFO frame packer
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   en_i, period_i        conversion enable and start period in cycles
//   adc_mask_i, os_sel_i  device read mask and oversampling select (latched per frame)
//   os_o, conv_o, busy_i  AD7606 oversampling pins, CONVST, wired BUSY
//   cs_o, rd_o, db_i      per-device chip selects, read strobe, shared data bus
//   frstdata_i            AD7606 FRSTDATA
//   fifo_wrreq_o/data_o   downstream FIFO write port; fifo_afull_i blocks a new frame
//   drop_cnt_o            saturating dropped-frame count
//   timeout_o, frst_err_o sticky BUSY timeout and FRSTDATA mismatch flags
module daq_frame_packer #(
    parameter int          NUM_ADC      = 8,
    parameter int          CH_PER_ADC   = 8,
    parameter int          DW           = 16,
    parameter int          CONV_LOW     = 4,
    parameter int          RD_LOW       = 3,
    parameter int          RD_HIGH      = 2,
    parameter int          BUSY_TIMEOUT = 1024,
    parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [23:0]        period_i,
    input  logic [NUM_ADC-1:0] adc_mask_i,
    input  logic [2:0]         os_sel_i,
    output logic [2:0]         os_o,
    output logic               conv_o,
    input  logic               busy_i,
    output logic [NUM_ADC-1:0] cs_o,
    output logic               rd_o,
    input  logic [DW-1:0]      db_i,
    input  logic               frstdata_i,
    output logic               fifo_wrreq_o,
    output logic [DW-1:0]      fifo_data_o,
    input  logic               fifo_afull_i,
    output logic [15:0]        drop_cnt_o,
    output logic               timeout_o,
    output logic               frst_err_o
);
    localparam int DEVW = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
    localparam int CHW  = (CH_PER_ADC > 1) ? $clog2(CH_PER_ADC) : 1;
    localparam int CW   = $clog2(BUSY_TIMEOUT + CONV_LOW + RD_LOW + RD_HIGH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_WAIT_HI, S_WAIT_LO, S_DECIDE, S_HDR, S_READ, S_DONE
    } state_t;
    typedef enum logic [1:0] {R_SETUP, R_LOW, R_HIGH} rphase_t;

    state_t             state, state_n;
    rphase_t            rph, rph_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [DEVW-1:0]    dev, dev_n;
    logic [CHW-1:0]     ch, ch_n;
    logic [23:0]        pcnt, pcnt_n, per_m1;
    logic               tick, pending, pending_n;
    logic [NUM_ADC-1:0] mask_q, mask_n, cs_n;
    logic [2:0]         os_n;
    logic [15:0]        seq, seq_n, drop_n;
    logic               tmo_n, ferr_n, wr_n, conv_n, rd_n, last_ch, last_ch_n;
    logic [DW-1:0]      data_n;
    logic [DEVW:0]      nd;

    // {found, index} of the lowest set mask bit at or above 'from'
    function automatic logic [DEVW:0] next_dev(input logic [NUM_ADC-1:0] m, input int from);
        logic [DEVW:0] r;
        r = '0;
        for (int i = NUM_ADC - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, DEVW'(i)};
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_n   = state;
        rph_n     = rph;
        cnt_n     = cnt;
        dev_n     = dev;
        ch_n      = ch;
        mask_n    = mask_q;
        os_n      = os_o;
        seq_n     = seq;
        drop_n    = drop_cnt_o;
        tmo_n     = timeout_o;
        ferr_n    = frst_err_o;
        wr_n      = 1'b0;
        data_n    = fifo_data_o;
        nd        = '0;
        last_ch   = (ch == CHW'(CH_PER_ADC - 1));

        // period_i of 0 behaves as 1; '>=' recovers if period_i shrinks below the count
        per_m1    = (period_i == 24'd0) ? 24'd0 : period_i - 24'd1;
        tick      = en_i && (pcnt >= per_m1);
        pcnt_n    = (!en_i || tick) ? 24'd0 : pcnt + 24'd1;
        pending_n = pending;
        if (!en_i)
            pending_n = 1'b0;
        else if (tick && state != S_IDLE)
            pending_n = 1'b1;

        case (state)
            S_IDLE: if (en_i && (tick || pending)) begin
                state_n   = S_CONV;
                cnt_n     = '0;
                pending_n = 1'b0;
                mask_n    = adc_mask_i;
                os_n      = os_sel_i;
            end
            S_CONV: if (cnt == CW'(CONV_LOW - 1)) begin
                state_n = S_WAIT_HI;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            S_WAIT_HI: if (busy_i) begin
                state_n = S_WAIT_LO;
                cnt_n   = '0;
            end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                state_n = S_IDLE;
                tmo_n   = 1'b1;
                drop_n  = sat_inc(drop_cnt_o);
                seq_n   = seq + 16'd1;
            end else cnt_n = cnt + 1'b1;
            S_WAIT_LO: if (!busy_i) begin
                state_n = S_DECIDE;
            end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                state_n = S_IDLE;
                tmo_n   = 1'b1;
                drop_n  = sat_inc(drop_cnt_o);
                seq_n   = seq + 16'd1;
            end else cnt_n = cnt + 1'b1;
            S_DECIDE: if (fifo_afull_i) begin
                state_n = S_IDLE;
                drop_n  = sat_inc(drop_cnt_o);
                seq_n   = seq + 16'd1;
            end else begin
                state_n = S_HDR;
                cnt_n   = '0;
                wr_n    = 1'b1;
                data_n  = DW'(SYNC_WORD);
            end
            // Each header word is set up on the edge entering its cycle
            S_HDR: if (cnt == '0) begin
                cnt_n  = CW'(1);
                wr_n   = 1'b1;
                data_n = DW'(seq);
            end else if (cnt == CW'(1)) begin
                cnt_n  = CW'(2);
                wr_n   = 1'b1;
                data_n = DW'(mask_q);
            end else begin
                nd = next_dev(mask_q, 0);
                if (nd[DEVW]) begin
                    state_n = S_READ;
                    rph_n   = R_SETUP;
                    dev_n   = nd[DEVW-1:0];
                    ch_n    = '0;
                    cnt_n   = '0;
                end else state_n = S_DONE;
            end
            S_READ: case (rph)
                R_SETUP: begin
                    rph_n = R_LOW;
                    cnt_n = '0;
                end
                R_LOW: if (cnt == CW'(RD_LOW - 1)) begin
                    // This edge ends the low phase: capture bus and FRSTDATA together
                    rph_n  = R_HIGH;
                    cnt_n  = '0;
                    wr_n   = 1'b1;
                    data_n = db_i;
                    if ((ch == '0) ? !frstdata_i : frstdata_i) ferr_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
                default: if (cnt == CW'(RD_HIGH - 1)) begin
                    if (!last_ch) begin
                        rph_n = R_LOW;
                        cnt_n = '0;
                        ch_n  = ch + 1'b1;
                    end else begin
                        nd = next_dev(mask_q, int'(dev) + 1);
                        if (nd[DEVW]) begin
                            rph_n = R_SETUP;
                            dev_n = nd[DEVW-1:0];
                            ch_n  = '0;
                            cnt_n = '0;
                        end else state_n = S_DONE;
                    end
                end else cnt_n = cnt + 1'b1;
            endcase
            S_DONE: begin
                seq_n   = seq + 16'd1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Strobes are registered from the next state so they are glitch-free and
        // line up with the state they belong to.
        last_ch_n = (ch_n == CHW'(CH_PER_ADC - 1));
        conv_n    = (state_n != S_CONV);
        rd_n      = !(state_n == S_READ && rph_n == R_LOW);
        cs_n      = '1;
        // After the last rd rise of a device, cs stays low for exactly one cycle
        if (state_n == S_READ && !(rph_n == R_HIGH && last_ch_n && cnt_n != '0))
            cs_n[dev_n] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            rph          <= R_SETUP;
            cnt          <= '0;
            dev          <= '0;
            ch           <= '0;
            pcnt         <= '0;
            pending      <= 1'b0;
            mask_q       <= '0;
            seq          <= '0;
            os_o         <= '0;
            drop_cnt_o   <= '0;
            timeout_o    <= 1'b0;
            frst_err_o   <= 1'b0;
            fifo_wrreq_o <= 1'b0;
            fifo_data_o  <= '0;
            conv_o       <= 1'b1;
            cs_o         <= '1;
            rd_o         <= 1'b1;
        end else begin
            state        <= state_n;
            rph          <= rph_n;
            cnt          <= cnt_n;
            dev          <= dev_n;
            ch           <= ch_n;
            pcnt         <= pcnt_n;
            pending      <= pending_n;
            mask_q       <= mask_n;
            seq          <= seq_n;
            os_o         <= os_n;
            drop_cnt_o   <= drop_n;
            timeout_o    <= tmo_n;
            frst_err_o   <= ferr_n;
            fifo_wrreq_o <= wr_n;
            fifo_data_o  <= data_n;
            conv_o       <= conv_n;
            cs_o         <= cs_n;
            rd_o         <= rd_n;
        end
    end
endmodule

// File: tb/tb_daq_frame_packer.sv
// tb/tb_daq_frame_packer.sv - scoreboard bench for daq_frame_packer with two AD7606 models
module tb_daq_frame_packer;
    logic        clk = 1'b0;
    logic        reset_i, en_i, busy_i, frstdata_i, fifo_afull_i;
    logic [23:0] period_i;
    logic [1:0]  adc_mask_i, cs_o;
    logic [2:0]  os_sel_i, os_o;
    logic        conv_o, rd_o, fifo_wrreq_o, timeout_o, frst_err_o;
    logic [15:0] db_i, fifo_data_o, drop_cnt_o;

    daq_frame_packer #(.NUM_ADC(2), .CH_PER_ADC(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .period_i(period_i),
        .adc_mask_i(adc_mask_i), .os_sel_i(os_sel_i), .os_o(os_o), .conv_o(conv_o),
        .busy_i(busy_i), .cs_o(cs_o), .rd_o(rd_o), .db_i(db_i), .frstdata_i(frstdata_i),
        .fifo_wrreq_o(fifo_wrreq_o), .fifo_data_o(fifo_data_o), .fifo_afull_i(fifo_afull_i),
        .drop_cnt_o(drop_cnt_o), .timeout_o(timeout_o), .frst_err_o(frst_err_o)
    );

    always #5 clk = ~clk;

    // Device models: BUSY rises 2 cycles after CONVST rises and lasts 20 cycles;
    // each device presents {dev, ch} and advances ch on every rd rise while selected.
    logic       conv_q = 1'b1, rd_q = 1'b1, stuck = 1'b0;
    logic [3:0] ch0 = '0, ch1 = '0;
    int         busy_cnt = 0;
    always @(posedge clk) begin
        conv_q <= conv_o;
        rd_q   <= rd_o;
        if (conv_q && !conv_o) begin
            ch0 <= '0;
            ch1 <= '0;
        end else if (!rd_q && rd_o) begin
            if (!cs_o[0]) ch0 <= ch0 + 4'd1;
            if (!cs_o[1]) ch1 <= ch1 + 4'd1;
        end
        if (!conv_q && conv_o && !stuck) busy_cnt <= 22;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy_i     = (busy_cnt > 0) && (busy_cnt <= 20);
    assign db_i       = !cs_o[0] ? {8'h00, 4'h0, ch0} : !cs_o[1] ? {8'h01, 4'h0, ch1} : 16'h0000;
    assign frstdata_i = !cs_o[0] ? (ch0 == 4'd0) : !cs_o[1] ? (ch1 == 4'd0) : 1'b0;

    // Scoreboard and bus-rule monitor
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    int          tests = 0, fails = 0, wr_seen = 0, viol = 0, cs0_low = 0;
    logic        watch_cs0 = 1'b0;

    always @(negedge clk) begin
        if (cs_o == 2'b00) viol++;
        if (!rd_o && cs_o == 2'b11) viol++;
        if (watch_cs0 && !cs_o[0]) cs0_low++;
        if (fifo_wrreq_o) begin
            wr_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL fifo_write: got unexpected word %h, required no write", fifo_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (fifo_data_o !== exp_w) begin
                    fails++;
                    $display("FAIL fifo_word: got %h, required %h", fifo_data_o, exp_w);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [15:0] seq, input logic [1:0] mask);
        exp_q.push_back(16'hA55A);
        exp_q.push_back(seq);
        exp_q.push_back({14'd0, mask});
        for (int d = 0; d < 2; d++)
            if (mask[d])
                for (int c = 0; c < 8; c++) exp_q.push_back({8'(d), 8'(c)});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_conv"}, 32'(conv_o), 32'd1);
        check({tag, "_cs"}, 32'(cs_o), 32'h3);
        check({tag, "_rd"}, 32'(rd_o), 32'd1);
        check({tag, "_wrreq"}, 32'(fifo_wrreq_o), 32'd0);
        check({tag, "_data"}, 32'(fifo_data_o), 32'd0);
        check({tag, "_os"}, 32'(os_o), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        check({tag, "_frst"}, 32'(frst_err_o), 32'd0);
    endtask

    task automatic do_reset();
        en_i    = 1'b0;
        reset_i = 1'b1;
        step(3);
        reset_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_empty(input int bound, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0;
        reset_i = 1'b1; en_i = 1'b0; period_i = 24'd2000; adc_mask_i = 2'b11;
        os_sel_i = 3'b101; fifo_afull_i = 1'b0;
        step(3);
        check_idle("reset");
        reset_i = 1'b0;

        // 1: both devices, two consecutive frames
        push_frame(16'h0000, 2'b11);
        push_frame(16'h0001, 2'b11);
        en_i = 1'b1;
        wait_empty(6000, "t1_frames");
        en_i = 1'b0;
        check("t1_os", 32'(os_o), 32'h5);
        check("t1_drop", 32'(drop_cnt_o), 32'd0);
        check("t1_frst", 32'(frst_err_o), 32'd0);
        check("t1_timeout", 32'(timeout_o), 32'd0);
        step(5);

        // 2: device 1 only; device 0 never selected
        do_reset();
        adc_mask_i = 2'b10;
        push_frame(16'h0000, 2'b10);
        cs0_low = 0;
        watch_cs0 = 1'b1;
        en_i = 1'b1;
        wait_empty(3000, "t2_frame");
        step(5);
        watch_cs0 = 1'b0;
        en_i = 1'b0;
        check("t2_cs0_low_cycles", 32'(cs0_low), 32'd0);

        // 3: FIFO almost full at DECIDE drops the frame
        do_reset();
        adc_mask_i = 2'b11;
        fifo_afull_i = 1'b1;
        en_i = 1'b1;
        n = 0;
        while (drop_cnt_o != 16'd1 && n < 3000) begin step(); n++; end
        check("t3_drop_seen", 32'(drop_cnt_o), 32'd1);
        fifo_afull_i = 1'b0;
        push_frame(16'h0001, 2'b11);
        wait_empty(3000, "t3_next_frame");
        check("t3_drop_final", 32'(drop_cnt_o), 32'd1);
        en_i = 1'b0;

        // 4: BUSY stuck low -> timeout after BUSY_TIMEOUT cycles in WAIT_HI
        do_reset();
        stuck = 1'b1;
        en_i = 1'b1;
        n = 0;
        while (conv_o != 1'b0 && n < 2500) begin step(); n++; end
        check("t4_conv_fell", 32'(conv_o), 32'd0);
        n = 0;
        while (conv_o != 1'b1 && n < 20) begin step(); n++; end
        check("t4_conv_rose", 32'(conv_o), 32'd1);
        step(1020);
        check("t4_timeout_early", 32'(timeout_o), 32'd0);
        step(10);
        check("t4_timeout", 32'(timeout_o), 32'd1);
        check("t4_drop", 32'(drop_cnt_o), 32'd1);
        check("t4_idle_cs", 32'(cs_o), 32'h3);
        check("t4_idle_rd", 32'(rd_o), 32'd1);
        stuck = 1'b0;
        push_frame(16'h0001, 2'b11);
        wait_empty(3000, "t4_next_frame");
        en_i = 1'b0;

        // 5: reset pulsed in the middle of READ
        do_reset();
        push_frame(16'h0000, 2'b11);
        w0 = wr_seen;
        en_i = 1'b1;
        n = 0;
        while (wr_seen < w0 + 6 && n < 3000) begin step(); n++; end
        check("t5_reached_read", 32'(wr_seen - w0), 32'd6);
        reset_i = 1'b1;
        step();
        check_idle("t5_after_reset");
        exp_q.delete();
        reset_i = 1'b0;
        push_frame(16'h0000, 2'b11);
        wait_empty(3000, "t5_next_frame");
        en_i = 1'b0;

        // 6: period shorter than a frame -> back-to-back frames; en_i drops mid-frame 3
        do_reset();
        period_i = 24'd50;
        push_frame(16'h0000, 2'b11);
        push_frame(16'h0001, 2'b11);
        push_frame(16'h0002, 2'b11);
        w0 = wr_seen;
        en_i = 1'b1;
        n = 0;
        while (wr_seen < w0 + 43 && n < 2000) begin step(); n++; end
        check("t6_third_started", 32'(wr_seen - w0), 32'd43);
        en_i = 1'b0;
        wait_empty(500, "t6_frames");
        step(300);
        check("t6_no_extra_writes", 32'(wr_seen - w0), 32'd57);
        check("t6_drop", 32'(drop_cnt_o), 32'd0);
        check("t6_frst", 32'(frst_err_o), 32'd0);

        check("bus_rule_violations", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
